// File: rtl/if_id_stall_ctrl.sv
// if_id_stall_ctrl: IF/ID register with stall/flush control, stall timeout and optional STALL_PERF_CNT_EN counters
module if_id_stall_ctrl #(
   parameter logic [31:0] NOP_INST  = 32'h0000_0013,
   parameter int unsigned MAX_STALL = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_req,
   input  logic        flush_req,
   input  logic [31:0] if_pc,
   input  logic [31:0] if_inst,
   output logic [31:0] id_pc,
   output logic [31:0] id_inst,
   output logic        id_valid,
   output logic        pc_write,
   output logic        id_ex_bubble,
   output logic        stall_timeout,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt
);
   typedef enum logic {RUN, STALL} state_t;
   localparam logic [3:0] MAX_LEN = 4'(MAX_STALL);
   state_t      state_q, state_d;
   logic [3:0]  run_len_q, run_len_d;
   logic [31:0] id_pc_q, id_pc_d, id_inst_q, id_inst_d;
   logic        id_valid_q, id_valid_d, stall_timeout_q, stall_timeout_d;
   logic        eff_stall;
   assign eff_stall    = stall_req & ~flush_req;
   assign pc_write     = ~eff_stall;
   assign id_ex_bubble = stall_req | flush_req;
   assign id_pc        = id_pc_q;
   assign id_inst      = id_inst_q;
   assign id_valid     = id_valid_q;
   assign stall_timeout = stall_timeout_q;
   // IF/ID next value: flush squashes, stall holds, otherwise advance
   always_comb begin
      id_pc_d    = flush_req ? 32'd0 : stall_req ? id_pc_q : if_pc;
      id_inst_d  = flush_req ? NOP_INST : stall_req ? id_inst_q : if_inst;
      id_valid_d = flush_req ? 1'b0 : stall_req ? id_valid_q : 1'b1;
   end
   // stall-run FSM next state; run length saturates at 15
   always_comb begin
      state_d   = eff_stall ? STALL : RUN;
      run_len_d = !eff_stall ? 4'd0 :
                  state_q == RUN ? 4'd1 :
                  run_len_q == 4'hF ? 4'hF : run_len_q + 4'd1;
   end
   // sticky timeout raised on the edge where the run length hits the limit
   always_comb begin
      stall_timeout_d = stall_timeout_q | (eff_stall & (run_len_d == MAX_LEN));
   end
   // state, IF/ID and timeout registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= RUN;
         run_len_q       <= 4'd0;
         id_pc_q         <= 32'd0;
         id_inst_q       <= NOP_INST;
         id_valid_q      <= 1'b0;
         stall_timeout_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         run_len_q       <= run_len_d;
         id_pc_q         <= id_pc_d;
         id_inst_q       <= id_inst_d;
         id_valid_q      <= id_valid_d;
         stall_timeout_q <= stall_timeout_d;
      end
   end
`ifdef STALL_PERF_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
   // saturating event counters
   always_comb begin
      stall_cnt_d = (eff_stall && stall_cnt_q != '1) ? stall_cnt_q + 32'd1 : stall_cnt_q;
      flush_cnt_d = (flush_req && flush_cnt_q != '1) ? flush_cnt_q + 32'd1 : flush_cnt_q;
   end
   // counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= 32'd0;
         flush_cnt_q <= 32'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end
`else
   assign stall_cnt = 32'd0;
   assign flush_cnt = 32'd0;
`endif
endmodule

// File: doc/if_id_stall_ctrl.md
# if_id_stall_ctrl

Pipeline-front control block that acts on the load-use stall request and the branch flush request. It owns the IF/ID pipeline register and drives the PC write enable and the ID/EX bubble insert, so the front end freezes or squashes in a single, consistent step. It sits between the fetch stage and the decode stage, alongside the hazard detection logic. It also watches for stalls that never resolve and, optionally, counts stall and flush events.

## Interface
Parameters:
- NOP_INST, 32'h0000_0013, instruction word loaded on reset/flush (addi x0,x0,0)
- MAX_STALL, 4, consecutive stall cycles that trip the timeout flag (range 1..15)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- stall_req  input  1  load-use stall request from hazard detection
- flush_req  input  1  taken-branch/jump flush request, resolved downstream
- if_pc  input  32  PC of the instruction being fetched
- if_inst  input  32  fetched instruction word
- id_pc  output  32  registered IF/ID PC
- id_inst  output  32  registered IF/ID instruction
- id_valid  output  1  IF/ID slot holds a real instruction
- pc_write  output  1  PC register enable (combinational)
- id_ex_bubble  output  1  force all ID/EX control bits to 0 this cycle (combinational)
- stall_timeout  output  1  sticky: stall held for MAX_STALL consecutive cycles
- stall_cnt  output  32  total stall cycles (only with STALL_PERF_CNT_EN)
- flush_cnt  output  32  total flush cycles (only with STALL_PERF_CNT_EN)

## Operation
- Priority: rst > flush_req > stall_req > normal advance.
- Combinational outputs:
  - pc_write = ~(stall_req & ~flush_req).
  - id_ex_bubble = stall_req | flush_req.
- IF/ID register update, at each rising edge:
  - rst: id_pc=0, id_inst=NOP_INST, id_valid=0.
  - flush_req: id_pc=0, id_inst=NOP_INST, id_valid=0. A simultaneous stall_req is ignored.
  - stall_req only: hold id_pc, id_inst, id_valid.
  - otherwise: id_pc=if_pc, id_inst=if_inst, id_valid=1.
- State machine, 2 states, with 4-bit counter run_len:
  - RUN: run_len=0. Go to STALL when stall_req & ~flush_req; run_len becomes 1 on entry.
  - STALL: stall_req & ~flush_req increments run_len. Any cycle without an effective stall returns to RUN.
  - flush_req in any state: next state RUN, run_len=0.
- stall_timeout:
  - Set on the edge where run_len would reach MAX_STALL.
  - Remains 1 until rst.
  - Does not alter the pipeline behaviour.
- run_len saturates at 15; it never wraps.

## Timing
- Reset values: id_pc=0, id_inst=NOP_INST, id_valid=0, stall_timeout=0, state=RUN, run_len=0, stall_cnt=0, flush_cnt=0.
- pc_write and id_ex_bubble are valid in the same cycle as their inputs; there is no register latency.
- IF/ID contents change one edge after the inputs are sampled.
- A one-cycle stall_req produces exactly one held IF/ID cycle and one bubble.
- Back-to-back stall cycles hold IF/ID for exactly N cycles.
- A flush asserted mid-stall squashes on that edge; the next cycle advances normally if both requests are low.
- rst asserted mid-stall clears everything on that edge, including stall_timeout.

## Configuration
- STALL_PERF_CNT_EN defined:
  - stall_cnt increments on every edge with stall_req & ~flush_req.
  - flush_cnt increments on every edge with flush_req.
  - Both counters saturate at 32'hFFFF_FFFF and clear on rst.
- STALL_PERF_CNT_EN undefined:
  - stall_cnt and flush_cnt are tied to 0.
  - No counter flops are instantiated.
  - All other behaviour is identical.

## Test plan
- Reset: hold rst 2 cycles, if_inst=32'hDEADBEEF -> id_inst=32'h00000013, id_valid=0, pc_write=1, id_ex_bubble=0.
- Normal flow: if_pc=0x10 / 0x14 on successive cycles -> id_pc follows one cycle later with id_valid=1; pc_write stays 1.
- Load-use: stall_req high 1 cycle while id_pc=0x14 -> pc_write=0 and id_ex_bubble=1 that cycle; id_pc stays 0x14 for one extra cycle, then advances to 0x18.
- Flush over stall: stall_req=1 and flush_req=1 together -> pc_write=1, id_ex_bubble=1, next id_inst=32'h00000013, id_valid=0, state RUN.
- Timeout: stall_req held 4 cycles with MAX_STALL=4 -> stall_timeout=1 after 4th edge; remains 1 after stall_req drops; clears only on rst.
- Counters (macro defined): 3 stall cycles, then 2 flush cycles -> stall_cnt=3, flush_cnt=2. Macro undefined -> both read 0.
